// File: rtl/icache_pg_pkg.sv
// Shared types and constants for the program-loaded instruction store.
package icache_pg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SEALED = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    localparam logic [15:0] END_WORD_DEF = 16'hF000;
    localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

    // Width that can hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/icache_pg_mem.sv
// Instruction array: one write port, one registered read port, no reset.
module icache_pg_mem #(
    parameter int unsigned IW    = 16,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [IW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [IW-1:0] rdata_o
);

    logic [IW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/icache_pg.sv
// Program-loaded instruction store: captures a word stream while pg is high,
// then serves PC-indexed fetches with one-cycle latency and NOP outside the program.
module icache_pg
    import icache_pg_pkg::*;
#(
    parameter int unsigned   IW       = 16,
    parameter int unsigned   DEPTH    = 32,
    parameter int unsigned   PCW      = 16,
    parameter logic [IW-1:0] END_WORD = IW'(END_WORD_DEF),
    parameter logic [IW-1:0] NOP_WORD = IW'(NOP_WORD_DEF),
    localparam int unsigned  CW       = cnt_width(DEPTH)
) (
    input  logic           clk,
    input  logic           rstz,
    input  logic           pg,
    input  logic [IW-1:0]  pg_instr,
    input  logic [PCW-1:0] pc,
    output logic [IW-1:0]  instr,
    output logic [CW-1:0]  count,
    output logic           done,
    output logic           overflow,
    output logic           run,
    inout  wire            dvdd,
    inout  wire            dgnd
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CMPW = (PCW > CW) ? PCW : CW;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          run_q;
    logic          hit_q;
    logic          we_c;
    logic [AW-1:0] waddr_c;
    logic          pc_hit_c;
    logic          is_end_c;
    logic [IW-1:0] rdata;

    // Power pins carry no logic; tie them off into a sink net.
    wire unused_pwr = dvdd ^ dgnd;

    assign is_end_c = (pg_instr == END_WORD);
    assign pc_hit_c = CMPW'(pc) < CMPW'(count_q);

    // Next-state, write-port and flag logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        we_c    = 1'b0;
        waddr_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (pg) begin
                    we_c    = 1'b1;
                    count_d = CW'(1);
                    if (is_end_c) begin
                        done_d  = 1'b1;
                        state_d = ST_SEALED;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (!pg) begin
                    state_d = ST_RUN;
                end else begin
                    if (count_q < CW'(DEPTH)) begin
                        we_c    = 1'b1;
                        waddr_c = count_q[AW-1:0];
                        count_d = count_q + CW'(1);
                    end else if (!is_end_c) begin
                        ovf_d = 1'b1;
                    end
                    if (is_end_c) begin
                        done_d  = 1'b1;
                        state_d = ST_SEALED;
                    end
                end
            end
            ST_SEALED: begin
                if (!pg) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            run_q   <= (state_d == ST_RUN);
            hit_q   <= (state_q == ST_RUN) && pc_hit_c;
        end
    end

    icache_pg_mem #(
        .IW    (IW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (we_c),
        .waddr_i (waddr_c),
        .wdata_i (pg_instr),
        .raddr_i (pc[AW-1:0]),
        .rdata_o (rdata)
    );

    // Array output is unreset, so a registered hit flag selects it or NOP.
    assign instr    = hit_q ? rdata : NOP_WORD;
    assign count    = count_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign run      = run_q;

endmodule

// File: tb/tb_icache_pg.sv
// Bench for icache_pg: a DEPTH=32 and a DEPTH=4 instance checked against a program-level model.
module tb_icache_pg;

    localparam int PH_FRESH  = 0;
    localparam int PH_LOAD   = 1;
    localparam int PH_SEALED = 2;
    localparam int PH_RUN    = 3;

    logic        clk;
    logic        rstz_a, pg_a, rstz_b, pg_b;
    logic [15:0] pgi_a, pc_a, pgi_b, pc_b;
    logic [15:0] instr_a, instr_b;
    logic [5:0]  count_a;
    logic [2:0]  count_b;
    logic        done_a, ovf_a, run_a, done_b, ovf_b, run_b;
    wire         dvdd_w, dgnd_w;

    assign dvdd_w = 1'b1;
    assign dgnd_w = 1'b0;

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_on = 1'b0;

    logic [15:0] m_mem   [2][32];
    int unsigned m_cnt   [2];
    bit          m_done  [2];
    bit          m_ovf   [2];
    int          m_ph    [2];
    logic [15:0] m_instr [2];

    logic [15:0] wl [5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};

    icache_pg u_a (
        .clk      (clk),
        .rstz     (rstz_a),
        .pg       (pg_a),
        .pg_instr (pgi_a),
        .pc       (pc_a),
        .instr    (instr_a),
        .count    (count_a),
        .done     (done_a),
        .overflow (ovf_a),
        .run      (run_a),
        .dvdd     (dvdd_w),
        .dgnd     (dgnd_w)
    );

    icache_pg #(.DEPTH(4)) u_b (
        .clk      (clk),
        .rstz     (rstz_b),
        .pg       (pg_b),
        .pg_instr (pgi_b),
        .pc       (pc_b),
        .instr    (instr_b),
        .count    (count_b),
        .done     (done_b),
        .overflow (ovf_b),
        .run      (run_b),
        .dvdd     (dvdd_w),
        .dgnd     (dgnd_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned dep(input int i);
        return (i == 0) ? 32 : 4;
    endfunction

    task automatic m_reset(input int i);
        m_cnt[i]   = 0;
        m_done[i]  = 1'b0;
        m_ovf[i]   = 1'b0;
        m_ph[i]    = PH_FRESH;
        m_instr[i] = 16'h0000;
    endtask

    // Program-level view: words append to a list until END or pg drops; fetch reads the list.
    task automatic m_edge(input int i, input bit pg_v, input logic [15:0] w, input logic [15:0] pcv);
        logic [4:0] a;
        if (m_ph[i] == PH_RUN) begin
            a = pcv[4:0];
            m_instr[i] = (32'(pcv) < m_cnt[i]) ? m_mem[i][a] : 16'h0000;
        end else begin
            m_instr[i] = 16'h0000;
            if (!pg_v) begin
                m_ph[i] = PH_RUN;
            end else if (m_ph[i] != PH_SEALED) begin
                if (m_cnt[i] < dep(i)) begin
                    m_mem[i][m_cnt[i]] = w;
                    m_cnt[i]++;
                end else if (w != 16'hF000) begin
                    m_ovf[i] = 1'b1;
                end
                if (w == 16'hF000) begin
                    m_done[i] = 1'b1;
                    m_ph[i]   = PH_SEALED;
                end else begin
                    m_ph[i] = PH_LOAD;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rstz_a) begin
        if (!rstz_a) m_reset(0);
        else         m_edge(0, pg_a, pgi_a, pc_a);
    end

    always @(posedge clk or negedge rstz_b) begin
        if (!rstz_b) m_reset(1);
        else         m_edge(1, pg_b, pgi_b, pc_b);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_instr", 32'(instr_a), 32'(m_instr[0]));
            chk("a_count", 32'(count_a), m_cnt[0]);
            chk("a_done",  32'(done_a),  32'(m_done[0]));
            chk("a_ovf",   32'(ovf_a),   32'(m_ovf[0]));
            chk("a_run",   32'(run_a),   32'(m_ph[0] == PH_RUN));
            chk("b_instr", 32'(instr_b), 32'(m_instr[1]));
            chk("b_count", 32'(count_b), m_cnt[1]);
            chk("b_done",  32'(done_b),  32'(m_done[1]));
            chk("b_ovf",   32'(ovf_b),   32'(m_ovf[1]));
            chk("b_run",   32'(run_b),   32'(m_ph[1] == PH_RUN));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstz_a = 1'b0; pg_a = 1'b0; pgi_a = '0; pc_a = '0;
        rstz_b = 1'b0; pg_b = 1'b0; pgi_b = '0; pc_b = '0;
        step();
        chk_on = 1'b1;
        chk("rst_count", 32'(count_a), 0);
        chk("rst_instr", 32'(instr_a), 0);
        chk("rst_run",   32'(run_a),   0);

        // Three-word program, then SEALED ignores words, then fetches.
        rstz_a = 1'b1; pg_a = 1'b1; pgi_a = 16'h1001; step();
        chk("ld1_count", 32'(count_a), 1);
        pgi_a = 16'h2002; step();
        pgi_a = 16'hF000; step();
        chk("ld3_count", 32'(count_a), 3);
        chk("ld3_done",  32'(done_a), 1);
        chk("model_cnt", m_cnt[0], 3);
        pgi_a = 16'h3003; step(); step();
        chk("sealed_count", 32'(count_a), 3);
        chk("sealed_run",   32'(run_a), 0);
        pg_a = 1'b0; pc_a = 16'd0; step();
        chk("enter_run", 32'(run_a), 1);
        chk("enter_nop", 32'(instr_a), 0);
        pc_a = 16'd0; step(); chk("f0", 32'(instr_a), 32'h1001);
        pc_a = 16'd1; step(); chk("f1", 32'(instr_a), 32'h2002);
        pc_a = 16'd2; step(); chk("f2", 32'(instr_a), 32'hF000);
        pc_a = 16'd3; step(); chk("f3", 32'(instr_a), 32'h0000);
        pg_a = 1'b1; pgi_a = 16'h4004; pc_a = 16'd1; step();
        chk("run_pg_run",   32'(run_a), 1);
        chk("run_pg_instr", 32'(instr_a), 32'h2002);
        pc_a = 16'd3; step();
        chk("run_pg_nowr", 32'(instr_a), 32'h0000);
        chk("run_pg_cnt",  32'(count_a), 3);

        // Reset in the middle of a load, then a one-word reload.
        rstz_a = 1'b0; pg_a = 1'b0; step();
        rstz_a = 1'b1; pg_a = 1'b1; pgi_a = 16'h5005; step();
        pgi_a = 16'h6006; step();
        chk("mid_count", 32'(count_a), 2);
        rstz_a = 1'b0; #1;
        chk("async_count", 32'(count_a), 0);
        step();
        rstz_a = 1'b1; pg_a = 1'b1; pgi_a = 16'hA000; step();
        chk("reload_count", 32'(count_a), 1);
        pg_a = 1'b0; step();
        pc_a = 16'd1; step(); chk("stale_nop", 32'(instr_a), 32'h0000);
        pc_a = 16'd0; step(); chk("reload_f0", 32'(instr_a), 32'hA000);

        // Straight to RUN with nothing loaded.
        rstz_a = 1'b0; step();
        rstz_a = 1'b1; pg_a = 1'b0; pc_a = 16'd0; step();
        chk("empty_run",   32'(run_a), 1);
        chk("empty_count", 32'(count_a), 0);
        pc_a = 16'd0;    step(); chk("empty_f0",    32'(instr_a), 32'h0000);
        pc_a = 16'hFFFF; step(); chk("empty_fffff", 32'(instr_a), 32'h0000);

        // pg falls on the same edge as END_WORD.
        rstz_a = 1'b0; step();
        rstz_a = 1'b1; pg_a = 1'b1; pgi_a = 16'h7007; step();
        pg_a = 1'b0; pgi_a = 16'hF000; step();
        chk("race_done",  32'(done_a), 0);
        chk("race_count", 32'(count_a), 1);
        chk("race_run",   32'(run_a), 1);
        pc_a = 16'd0; step(); chk("race_f0", 32'(instr_a), 32'h7007);
        pc_a = 16'd1; step(); chk("race_f1", 32'(instr_a), 32'h0000);

        // DEPTH=4: five words overflow, END still seals.
        rstz_b = 1'b1; pg_b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pgi_b = wl[k];
            step();
        end
        chk("ovf_count", 32'(count_b), 4);
        chk("ovf_flag",  32'(ovf_b), 1);
        chk("ovf_done0", 32'(done_b), 0);
        pgi_b = 16'hF000; step();
        chk("ovf_done",  32'(done_b), 1);
        chk("ovf_cnt2",  32'(count_b), 4);
        chk("model_ovf", 32'(m_ovf[1]), 1);
        pg_b = 1'b0; step();
        pc_b = 16'd3; step(); chk("d4_f3", 32'(instr_b), 32'h0044);
        pc_b = 16'd4; step(); chk("d4_f4", 32'(instr_b), 32'h0000);
        pc_b = 16'd0; step(); chk("d4_f0", 32'(instr_b), 32'h0011);

        // DEPTH=4: program consisting only of END_WORD.
        rstz_b = 1'b0; step();
        rstz_b = 1'b1; pg_b = 1'b1; pgi_b = 16'hF000; step();
        chk("endonly_count", 32'(count_b), 1);
        chk("endonly_done",  32'(done_b), 1);
        pg_b = 1'b0; step();
        pc_b = 16'd0; step(); chk("endonly_f0", 32'(instr_b), 32'hF000);
        step();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
